mvu_agu: RTL and testbench
==========================

# mvu_agu

Parametrised nested-loop address generator for the MVU datapath. It is the next-generation replacement for the fixed five-level jump/length address logic, and serves the weight, input, scaler, bias and output streams. A job starts on `start`, and the block emits one address per enabled step for `countdown` steps. Each step applies a signed jump chosen by an N-level loop nest. The block reports the loop level taken on each step and raises `done` and `irq` at job end.

## Interface
Parameters:
- `BADDR`, 15: address width.
- `BJUMP`, 15: jump width, signed two's complement.
- `BLENGTH`, 15: loop-length counter width.
- `NJUMPS`, 5: loop levels, ≥ 2.
- `BCNTDWN`, 29: step-count width.

Ports:
- `clk`  in  1  clock; one clock domain; everything rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job start pulse.
- `step_en`  in  1  consumer ready; the step advances when `valid_o && step_en`.
- `baseaddr`  in  BADDR  start address.
- `jump`  in  NJUMPS*BJUMP  jump per level; level i at bits [i*BJUMP +: BJUMP].
- `length`  in  (NJUMPS-1)*BLENGTH  reload value for levels 1..NJUMPS-1; level i at bits [(i-1)*BLENGTH +: BLENGTH].
- `countdown`  in  BCNTDWN  number of addresses to emit.
- `irq_clr`  in  1  clears `irq`.
- `addr_o`  out  BADDR  current address.
- `valid_o`  out  1  `addr_o` valid.
- `trig_o`  out  NJUMPS  one-hot: level applied after the current address.
- `busy`  out  1  job active.
- `done`  out  1  one-cycle end-of-job pulse.
- `irq`  out  1  sticky completion interrupt.

## Operation
States: IDLE and RUN.

Starting a job:
- In IDLE, `start` latches `jump`, `length`, `baseaddr` and `countdown`. Inputs may change afterwards.
- It also loads `addr`=`baseaddr`, `c[i]`=`length[i]` for every level, and `rem`=`countdown`.
- If `countdown`≠0, go to RUN.
- If `countdown`=0, stay in IDLE, pulse `done` next cycle, set `irq`, and emit no addresses.
- `start` in RUN is ignored.

Level selection in RUN (combinational):
- k = the smallest i in 1..NJUMPS-1 with `c[i]`≠0.
- If no such i exists, k=0.
- `trig_o` = one-hot(k).

On each advancing step:
- `addr` += sign-extended `jump[k]`, modulo 2^BADDR; wrap-around is silent.
- If k≥1: `c[k]`--, and `c[1..k-1]` reload from `length`.
- If k=0: all `c` reload.
- `rem`--.
- If `rem` was 1: go to IDLE, pulse `done`, set `irq`.

Loop semantics:
- Level i performs `length[i]` level-i jumps per pass of level i+1.
- Level 0 jumps repeat indefinitely, bounded only by `countdown`.

Interrupt:
- `irq` stays set until `irq_clr`.
- A set and an `irq_clr` in the same cycle: the set wins.

Stalls:
- With `step_en`=0, all state holds and `addr_o`/`trig_o` stay stable.

Reset:
- Asynchronous `rst_n` low at any time, including mid-job, forces IDLE.
- The job is discarded and `done` is not pulsed.

## Timing
Reset values:
- `addr_o`=0, `valid_o`=0, `trig_o`=0, `busy`=0, `done`=0, `irq`=0.
- All internal counters = 0.

Job start:
- `start` is sampled at edge T.
- `busy`=`valid_o`=1 from T+1.
- `addr_o`=`baseaddr` at T+1.

Output timing:
- `valid_o` = `busy`; it does not depend on `step_en`.
- `addr_o` and `trig_o` are derived from registers only; there is no combinational path from `start` or `step_en`.

Steady-state throughput:
- One address per cycle when `step_en` is held at 1.

Job end:
- The final step is accepted at edge E.
- At E+1: `busy`=0, `valid_o`=0, `done`=1 for exactly one cycle, and `irq`=1.
- A new `start` is accepted at E+1.
- Zero-countdown job: `done` at T+1.

## Configuration
- `MVU_AGU_IRQ_EN` defined: `irq` and `irq_clr` behave as described above.
- `MVU_AGU_IRQ_EN` undefined: the `irq` flop is not built, `irq` is tied to 0, and `irq_clr` is ignored.
- `done` is unaffected by the macro in both cases.

## Test plan
- **Nested sequence.** NJUMPS=3, base=10, jump={100,1,4} for levels {0,1,2}, length[1]=2, length[2]=1, countdown=8, `step_en`=1 →
  - `addr_o` = 10,11,12,16,17,18,118,119;
  - `trig_o` levels = 1,1,2,1,1,0,1,1;
  - `done` one cycle after 119.
- **Stalls.** Same job with `step_en` toggling 1,0,1,0 → the same address sequence; each address holds during stall cycles; total cycles = 8 + stall count.
- **Negative jump and wrap.** BADDR=15, base=1, jump[1]=-2, length[1]=3, countdown=3 → addresses 1, 32767, 32765.
- **Zero countdown.** countdown=0 → `valid_o` never high, `done` at T+1, `irq`=1; with `irq_clr` asserted in the same cycle as `done`, `irq` still =1.
- **Start while busy.** A `start` during RUN with different config → ignored and the original sequence completes; reset asserted mid-job → all outputs 0 immediately, no `done`.
- **Macro off.** Build without `MVU_AGU_IRQ_EN` → `irq` is 0 throughout the nested-sequence test, while `done` behaves as in the first scenario.

Source files
------------

// File: rtl/mvu_agu_if.sv
// mvu_agu_if: job configuration, step handshake and status bundle for mvu_agu.
interface mvu_agu_if #(
  parameter int BADDR   = 15,
  parameter int BJUMP   = 15,
  parameter int BLENGTH = 15,
  parameter int NJUMPS  = 5,
  parameter int BCNTDWN = 29
);
  logic                           start;
  logic                           step_en;
  logic [BADDR-1:0]               baseaddr;
  logic [NJUMPS*BJUMP-1:0]        jump;
  logic [(NJUMPS-1)*BLENGTH-1:0]  length;
  logic [BCNTDWN-1:0]             countdown;
  logic                           irq_clr;
  logic [BADDR-1:0]               addr_o;
  logic                           valid_o;
  logic [NJUMPS-1:0]              trig_o;
  logic                           busy;
  logic                           done;
  logic                           irq;
  modport master (
    output start, step_en, baseaddr, jump, length, countdown, irq_clr,
    input  addr_o, valid_o, trig_o, busy, done, irq
  );
  modport slave (
    input  start, step_en, baseaddr, jump, length, countdown, irq_clr,
    output addr_o, valid_o, trig_o, busy, done, irq
  );
endinterface

// File: rtl/mvu_agu.sv
// mvu_agu: nested-loop address generator with signed per-level jumps.
// Define MVU_AGU_IRQ_EN to build the sticky irq flop; otherwise irq is tied low.
module mvu_agu #(
  parameter int BADDR   = 15,
  parameter int BJUMP   = 15,
  parameter int BLENGTH = 15,
  parameter int NJUMPS  = 5,
  parameter int BCNTDWN = 29
) (
  input logic        clk,
  input logic        rst_n,
  mvu_agu_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                         state_q, state_d;
  logic [BADDR-1:0]               addr_q, addr_d;
  logic [BLENGTH-1:0]             c_q [1:NJUMPS-1];
  logic [BLENGTH-1:0]             c_d [1:NJUMPS-1];
  logic [BCNTDWN-1:0]             rem_q, rem_d;
  logic [NJUMPS*BJUMP-1:0]        jump_q, jump_d;
  logic [(NJUMPS-1)*BLENGTH-1:0]  len_q, len_d;
  logic                           done_q, done_d;
  logic signed [BJUMP-1:0]        jk;
  int                             k;
  // Innermost level with iterations left takes the step; none left means level 0.
  always_comb begin
    k = 0;
    for (int i = NJUMPS-1; i >= 1; i--) k = (c_q[i] != '0) ? i : k;
    jk = jump_q[k*BJUMP +: BJUMP];
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    c_d     = c_q;
    rem_d   = rem_q;
    jump_d  = jump_q;
    len_d   = len_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start) begin
      jump_d  = bus.jump;
      len_d   = bus.length;
      addr_d  = bus.baseaddr;
      rem_d   = bus.countdown;
      for (int i = 1; i < NJUMPS; i++) c_d[i] = bus.length[(i-1)*BLENGTH +: BLENGTH];
      state_d = (bus.countdown != '0) ? RUN : IDLE;
      done_d  = (bus.countdown == '0);
    end else if (state_q == RUN && bus.step_en) begin
      addr_d  = addr_q + BADDR'(jk);
      for (int i = 1; i < NJUMPS; i++)
        c_d[i] = (k == 0 || i < k) ? len_q[(i-1)*BLENGTH +: BLENGTH] :
                 (i == k) ? c_q[i] - BLENGTH'(1) : c_q[i];
      rem_d   = rem_q - BCNTDWN'(1);
      state_d = (rem_q == BCNTDWN'(1)) ? IDLE : RUN;
      done_d  = (rem_q == BCNTDWN'(1));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      c_q     <= '{default: '0};
      rem_q   <= '0;
      jump_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      jump_q  <= jump_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end
  assign bus.addr_o  = addr_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.valid_o = (state_q == RUN);
  assign bus.trig_o  = (state_q == RUN) ? NJUMPS'(1) << k : '0;
  assign bus.done    = done_q;
`ifdef MVU_AGU_IRQ_EN
  logic irq_q;
  // Completion sets irq in the same edge as done is registered, so it wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= done_d | (irq_q & ~bus.irq_clr);
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_mvu_agu.sv
// tb_mvu_agu: directed self-checking bench for mvu_agu with a three-level loop nest.
module tb_mvu_agu;
`ifdef MVU_AGU_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int nest_a [8] = '{10, 11, 12, 16, 17, 18, 118, 119};
  int nest_l [8] = '{1, 1, 2, 1, 1, 0, 1, 1};
  mvu_agu_if #(.NJUMPS(3)) bus ();
  mvu_agu #(.NJUMPS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic do_start(input logic [14:0] base, input logic [14:0] j0, input logic [14:0] j1,
                          input logic [14:0] j2, input logic [14:0] l1, input logic [14:0] l2,
                          input logic [28:0] cd);
    bus.start = 1'b1;
    bus.baseaddr = base;
    bus.jump = {j2, j1, j0};
    bus.length = {l2, l1};
    bus.countdown = cd;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.addr_o !== 15'd0 || bus.valid_o !== 1'b0 || bus.trig_o !== 3'b000) begin failures++; $display("FAIL reset_data: addr=%0d valid=%b trig=%b expected 0 0 000", bus.addr_o, bus.valid_o, bus.trig_o); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.irq !== 1'b0) begin failures++; $display("FAIL reset_status: busy=%b done=%b irq=%b expected 0 0 0", bus.busy, bus.done, bus.irq); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", bus.busy, bus.valid_o); end
  endtask
  task automatic test_nested;
    bus.step_en = 1'b1;
    do_start(10, 100, 1, 4, 2, 1, 8);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.addr_o !== 15'(nest_a[i]) || bus.trig_o !== 3'(1 << nest_l[i]) || bus.valid_o !== 1'b1) begin failures++; $display("FAIL nested_step%0d: addr=%0d trig=%b valid=%b expected addr=%0d trig=%b valid=1", i, bus.addr_o, bus.trig_o, bus.valid_o, nest_a[i], 3'(1 << nest_l[i])); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid_o !== 1'b0 || bus.irq !== IRQ_EN) begin failures++; $display("FAIL nested_end: done=%b busy=%b valid=%b irq=%b expected 1 0 0 %b", bus.done, bus.busy, bus.valid_o, bus.irq, IRQ_EN); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.irq !== IRQ_EN) begin failures++; $display("FAIL nested_done_pulse: done=%b irq=%b expected 0 %b", bus.done, bus.irq, IRQ_EN); end
  endtask
  task automatic test_stalls;
    int idx = 0;
    int cyc = 0;
    do_start(10, 100, 1, 4, 2, 1, 8);
    while (idx < 8 && cyc < 60) begin
      bus.step_en = (cyc % 2 == 0);
      checks++; if (bus.addr_o !== 15'(nest_a[idx]) || bus.trig_o !== 3'(1 << nest_l[idx]) || bus.valid_o !== 1'b1) begin failures++; $display("FAIL stall_cycle%0d: addr=%0d trig=%b valid=%b expected addr=%0d trig=%b valid=1", cyc, bus.addr_o, bus.trig_o, bus.valid_o, nest_a[idx], 3'(1 << nest_l[idx])); end
      if (bus.step_en) idx++;
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc !== 15 || bus.done !== 1'b1 || bus.valid_o !== 1'b0) begin failures++; $display("FAIL stall_total: cycles=%0d done=%b valid=%b expected 15 1 0", cyc, bus.done, bus.valid_o); end
    bus.step_en = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_wrap_back_to_back;
    int wa [3] = '{1, 32767, 32765};
    do_start(1, 0, 15'h7FFE, 0, 3, 0, 3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.addr_o !== 15'(wa[i]) || bus.trig_o !== 3'b010) begin failures++; $display("FAIL wrap_step%0d: addr=%0d trig=%b expected addr=%0d trig=010", i, bus.addr_o, bus.trig_o, wa[i]); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_end: done=%b busy=%b expected 1 0", bus.done, bus.busy); end
    do_start(7, 3, 0, 0, 0, 0, 1);
    checks++; if (bus.addr_o !== 15'd7 || bus.trig_o !== 3'b001 || bus.valid_o !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL b2b_start: addr=%0d trig=%b valid=%b done=%b expected 7 001 1 0", bus.addr_o, bus.trig_o, bus.valid_o, bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.valid_o !== 1'b0 || bus.addr_o !== 15'd10) begin failures++; $display("FAIL b2b_end: done=%b valid=%b addr=%0d expected 1 0 10", bus.done, bus.valid_o, bus.addr_o); end
    @(negedge clk);
  endtask
  task automatic test_zero_countdown;
    bus.irq_clr = 1'b1;
    @(negedge clk);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_clear: irq=%b expected 0", bus.irq); end
    do_start(55, 0, 0, 0, 0, 0, 0);
    bus.irq_clr = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.valid_o !== 1'b0 || bus.busy !== 1'b0 || bus.irq !== IRQ_EN) begin failures++; $display("FAIL zero_done: done=%b valid=%b busy=%b irq=%b expected 1 0 0 %b", bus.done, bus.valid_o, bus.busy, bus.irq, IRQ_EN); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.valid_o !== 1'b0 || bus.irq !== IRQ_EN) begin failures++; $display("FAIL zero_after: done=%b valid=%b irq=%b expected 0 0 %b", bus.done, bus.valid_o, bus.irq, IRQ_EN); end
  endtask
  task automatic test_start_while_busy;
    do_start(10, 100, 1, 4, 2, 1, 8);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.addr_o !== 15'(nest_a[i]) || bus.trig_o !== 3'(1 << nest_l[i])) begin failures++; $display("FAIL busy_step%0d: addr=%0d trig=%b expected addr=%0d trig=%b", i, bus.addr_o, bus.trig_o, nest_a[i], 3'(1 << nest_l[i])); end
      bus.start = (i == 1);
      bus.baseaddr = 15'd500;
      bus.countdown = 29'd3;
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL busy_end: done=%b busy=%b expected 1 0", bus.done, bus.busy); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_job;
    do_start(10, 100, 1, 4, 2, 1, 8);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.addr_o !== 15'd12 || bus.busy !== 1'b1) begin failures++; $display("FAIL midjob_pre: addr=%0d busy=%b expected 12 1", bus.addr_o, bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.addr_o !== 15'd0 || bus.valid_o !== 1'b0 || bus.trig_o !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.irq !== 1'b0) begin failures++; $display("FAIL midjob_reset: addr=%0d valid=%b trig=%b busy=%b done=%b irq=%b expected all 0", bus.addr_o, bus.valid_o, bus.trig_o, bus.busy, bus.done, bus.irq); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midjob_hold%0d: done=%b busy=%b expected 0 0", i, bus.done, bus.busy); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.valid_o !== 1'b0 || bus.addr_o !== 15'd0) begin failures++; $display("FAIL midjob_release: done=%b valid=%b addr=%0d expected 0 0 0", bus.done, bus.valid_o, bus.addr_o); end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.step_en = 1'b1;
    bus.baseaddr = '0;
    bus.jump = '0;
    bus.length = '0;
    bus.countdown = '0;
    bus.irq_clr = 1'b0;
    test_reset;
    test_nested;
    test_stalls;
    test_wrap_back_to_back;
    test_zero_countdown;
    test_start_while_busy;
    test_reset_mid_job;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
